// File: rtl/example_uart_tx_bus_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// FSM states, register word offsets, STATUS bit positions and a divisor helper.
package uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

    // Word offsets inside the 16-byte window (address[3:2])
    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    // STATUS register layout
    localparam int STAT_FULL       = 0;
    localparam int STAT_EMPTY      = 1;
    localparam int STAT_BUSY       = 2;
    localparam int STAT_OVERFLOW   = 3;
    localparam int STAT_COUNT_LSB  = 8;
    localparam int STAT_COUNT_BITS = 4;

    // A programmed divisor of zero is treated as one clock per bit
    function automatic logic [15:0] effective_divisor(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/example_uart_tx_bus_if.sv
// Data-memory bus slice seen by the UART transmitter.
// The core side drives the request (master); the peripheral answers reads (slave).
interface example_uart_tx_bus_if;

    logic [31:0] address;
    logic        read_enable;
    logic        write_enable;
    logic [3:0]  byte_enable;
    logic [31:0] write_data;
    logic [31:0] read_data;

    modport master (
        output address, read_enable, write_enable, byte_enable, write_data,
        input  read_data
    );

    modport slave (
        input  address, read_enable, write_enable, byte_enable, write_data,
        output read_data
    );

endinterface

// File: rtl/example_uart_tx_bus_fifo.sv
// Synchronous TX byte FIFO with first-word-fall-through read data.
// A push while full is dropped; a pop while empty is ignored.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage array; contents need no reset because count guards every read
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/example_uart_tx_bus.sv
// Memory-mapped console transmitter: register window on the data bus,
// TX FIFO and an 8N1 serialiser with a programmable clocks-per-bit divisor.
// Optional feature macro: UART_TX_IRQ_EN adds the CTRL register and o_irq.
module example_uart_tx_bus
    import uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h1100_0000,
    parameter int          FIFO_DEPTH      = 8,
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd868
) (
    input  logic                  clock,
    input  logic                  reset,
    example_uart_tx_bus_if.slave  bus,
    output logic                  o_tx
`ifdef UART_TX_IRQ_EN
    ,
    output logic                  o_irq
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             hit;
    logic [1:0]       word;
    logic             wr_hit;
    logic             push_req;
    logic             fifo_pop;
    logic [7:0]       fifo_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [15:0]      divisor;
    logic [15:0]      load_div;
    logic             overflow;
    tx_state_t        state;
    logic [7:0]       shift;
    logic [2:0]       bit_idx;
    logic [15:0]      baud_cnt;
    logic [15:0]      frame_div;
    logic             tx_reg;
    logic [31:0]      status;
    logic             unused_bits;

`ifdef UART_TX_IRQ_EN
    logic             irq_enable;
    logic             irq_reg;
`endif

    assign hit         = (bus.address[31:4] == BASE_ADDR[31:4]);
    assign word        = bus.address[3:2];
    assign wr_hit      = hit && bus.write_enable;
    assign push_req    = wr_hit && (word == REG_TXDATA) && bus.byte_enable[0];
    assign load_div    = effective_divisor(divisor);
    assign fifo_pop    = !fifo_empty &&
                         ((state == ST_IDLE) || ((state == ST_STOP) && (baud_cnt == 16'd0)));
    assign o_tx        = tx_reg;
    assign unused_bits = ^{bus.address[1:0], bus.byte_enable[3:2], bus.write_data[31:16]};

    uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_req),
        .push_data (bus.write_data[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Divisor register with per-lane writes and the sticky overflow flag
    always_ff @(posedge clock) begin
        if (reset) begin
            divisor  <= DEFAULT_DIVISOR;
            overflow <= 1'b0;
        end else begin
            if (wr_hit && (word == REG_DIVISOR)) begin
                if (bus.byte_enable[0]) divisor[7:0]  <= bus.write_data[7:0];
                if (bus.byte_enable[1]) divisor[15:8] <= bus.write_data[15:8];
            end
            if (push_req && fifo_full) begin
                overflow <= 1'b1;
            end else if (wr_hit && (word == REG_STATUS) && bus.byte_enable[0] &&
                         bus.write_data[STAT_OVERFLOW]) begin
                overflow <= 1'b0;
            end
        end
    end

    // Frame FSM; o_tx is registered so it always reflects the state being entered
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            tx_reg    <= 1'b1;
            shift     <= 8'h00;
            bit_idx   <= 3'd0;
            baud_cnt  <= 16'd0;
            frame_div <= 16'd1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        shift     <= fifo_data;
                        frame_div <= load_div;
                        baud_cnt  <= load_div - 16'd1;
                        tx_reg    <= 1'b0;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_cnt == 16'd0) begin
                        baud_cnt <= frame_div - 16'd1;
                        bit_idx  <= 3'd0;
                        tx_reg   <= shift[0];
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (baud_cnt == 16'd0) begin
                        baud_cnt <= frame_div - 16'd1;
                        if (bit_idx == 3'd7) begin
                            tx_reg <= 1'b1;
                            state  <= ST_STOP;
                        end else begin
                            shift   <= {1'b0, shift[7:1]};
                            tx_reg  <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (baud_cnt == 16'd0) begin
                        if (!fifo_empty) begin
                            shift     <= fifo_data;
                            frame_div <= load_div;
                            baud_cnt  <= load_div - 16'd1;
                            tx_reg    <= 1'b0;
                            state     <= ST_START;
                        end else begin
                            tx_reg <= 1'b1;
                            state  <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                default: begin
                    tx_reg <= 1'b1;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef UART_TX_IRQ_EN
    // Interrupt enable and a registered TX-empty interrupt
    always_ff @(posedge clock) begin
        if (reset) begin
            irq_enable <= 1'b0;
            irq_reg    <= 1'b0;
        end else begin
            if (wr_hit && (word == REG_CTRL) && bus.byte_enable[0]) begin
                irq_enable <= bus.write_data[0];
            end
            irq_reg <= irq_enable && fifo_empty && (state == ST_IDLE);
        end
    end

    assign o_irq = irq_reg;
`endif

    // Combinational register read path, zero whenever there is no hitting read
    always_comb begin
        status                                        = 32'h0;
        status[STAT_FULL]                             = fifo_full;
        status[STAT_EMPTY]                            = fifo_empty;
        status[STAT_BUSY]                             = (state != ST_IDLE);
        status[STAT_OVERFLOW]                         = overflow;
        status[STAT_COUNT_LSB +: STAT_COUNT_BITS]     = STAT_COUNT_BITS'(fifo_count);
        bus.read_data                                 = 32'h0;
        if (hit && bus.read_enable) begin
            case (word)
                REG_STATUS:  bus.read_data = status;
                REG_DIVISOR: bus.read_data = {16'h0, divisor};
`ifdef UART_TX_IRQ_EN
                REG_CTRL:    bus.read_data = {31'h0, irq_enable};
`endif
                default:     bus.read_data = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_example_uart_tx_bus.sv
// Scoreboard bench for example_uart_tx_bus. The model keeps every accepted
// byte with its write edge, pop edge and divisor, and derives register
// contents and expected serial waveforms from those records.
module tb_example_uart_tx_bus;

    localparam logic [31:0] BASE  = 32'h1100_0000;
    localparam int          DEPTH = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic o_tx;
`ifdef UART_TX_IRQ_EN
    logic o_irq;
`endif

    example_uart_tx_bus_if bus ();

    example_uart_tx_bus #(
        .BASE_ADDR       (BASE),
        .FIFO_DEPTH      (DEPTH),
        .DEFAULT_DIVISOR (16'd868)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .o_tx  (o_tx)
`ifdef UART_TX_IRQ_EN
        ,
        .o_irq (o_irq)
`endif
    );

    typedef struct {
        logic [7:0] data;
        int         w;
        int         s;
        int         d;
    } frame_t;

    frame_t      frames[$];
    frame_t      exp_q[$];
    logic [31:0] rd_q[$];
    logic [15:0] m_div;
    logic        m_ovf;
    logic        m_irq_en;
    int          last_end;
    int          last_sampled = 0;
    bit          mon_busy = 0;
    int          cyc = 0;
    logic        rst_seen = 1'b1;
    int          n_compared = 0;
    int          n_mismatched = 0;

    // Free-running clock
    always #5 clock = ~clock;

    // Edge counter and a record of whether the last edge was a reset edge
    always @(posedge clock) begin
        cyc      <= cyc + 1;
        rst_seen <= reset;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, actual, expected);
        end
    endtask

    // Bytes sitting in the FIFO after edge c
    function automatic int m_count(input int c);
        int n = 0;
        foreach (frames[i]) if (frames[i].w <= c && c < frames[i].s) n++;
        return n;
    endfunction

    // Some frame is on the line after edge c
    function automatic bit m_busy(input int c);
        foreach (frames[i]) if (frames[i].s <= c && c < frames[i].s + 10 * frames[i].d) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] addr);
        logic [31:0] r = 32'h0;
        int          n = m_count(cyc);
        if (addr[31:4] != BASE[31:4]) return 32'h0;
        case (addr[3:2])
            2'd1: begin
                r[0]    = (n == DEPTH);
                r[1]    = (n == 0);
                r[2]    = m_busy(cyc);
                r[3]    = m_ovf;
                r[11:8] = 4'(n);
            end
            2'd2: r = {16'h0, m_div};
`ifdef UART_TX_IRQ_EN
            2'd3: r = {31'h0, m_irq_en};
`endif
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    // Expected line level after edge c for a given frame
    function automatic logic frame_bit(input frame_t f, input int c);
        int k;
        if (c < f.s) return 1'b1;
        k = (c - f.s) / f.d;
        if (k == 0) return 1'b0;
        if (k <= 8) return f.data[k-1];
        return 1'b1;
    endfunction

    task automatic model_push(input logic [7:0] data, input int n);
        int     occ = 0;
        frame_t f;
        foreach (frames[i]) if (frames[i].s >= n) occ++;
        if (occ >= DEPTH) begin
            m_ovf = 1'b1;
            return;
        end
        f.data   = data;
        f.w      = n;
        f.d      = (m_div == 16'd0) ? 1 : int'(m_div);
        f.s      = (n + 1 > last_end) ? n + 1 : last_end;
        last_end = f.s + 10 * f.d;
        frames.push_back(f);
        exp_q.push_back(f);
    endtask

    // One bus cycle; the model is updated for the edge that samples it
    task automatic applyStimulus(input bit wr, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
        int n;
        n                = cyc + 1;
        bus.address      = addr;
        bus.byte_enable  = be;
        bus.write_data   = data;
        bus.write_enable = wr;
        bus.read_enable  = !wr;
        if (!wr) begin
            rd_q.push_back(m_read(addr));
        end else if (addr[31:4] == BASE[31:4]) begin
            case (addr[3:2])
                2'd0: if (be[0]) model_push(data[7:0], n);
                2'd1: if (be[0] && data[3]) m_ovf = 1'b0;
                2'd2: begin
                    if (be[0]) m_div[7:0]  = data[7:0];
                    if (be[1]) m_div[15:8] = data[15:8];
                end
`ifdef UART_TX_IRQ_EN
                2'd3: if (be[0]) m_irq_en = data[0];
`endif
                default: ;
            endcase
        end
        @(posedge clock);
        #1;
        bus.write_enable = 1'b0;
        bus.read_enable  = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drain();
        int guard = 0;
        while ((exp_q.size() != 0 || mon_busy) && guard < 20000) begin
            @(posedge clock);
            guard++;
        end
        #1;
        if (guard >= 20000) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL drain_timeout: %0d frames still pending", exp_q.size());
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        exp_q.delete();
        frames.delete();
        last_end = 0;
        m_div    = 16'd868;
        m_ovf    = 1'b0;
        m_irq_en = 1'b0;
        @(posedge clock);
        @(negedge clock);
        checkOutput("tx_after_reset", {31'h0, o_tx}, 32'h1);
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    // Read scoreboard: every read strobe pops one expected value
    always @(negedge clock) begin
        if (bus.read_enable) begin
            if (rd_q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL read_unexpected: got 0x%08h with no expectation queued", bus.read_data);
            end else begin
                checkOutput("read_data", bus.read_data, rd_q.pop_front());
            end
        end
    end

    // Serial monitor: pops expected frames and follows the line cycle by cycle
    initial begin
        frame_t e;
        int     target;
        int     fin;
        int     bad_cyc;
        bit     aborted;
        bit     bad;
        logic   exp_bit;
        logic   bad_act;
        logic   bad_exp;
        forever begin
            @(negedge clock);
            if (exp_q.size() != 0) begin
                e        = exp_q.pop_front();
                mon_busy = 1;
                aborted  = 0;
                bad      = 0;
                bad_cyc  = 0;
                bad_act  = 1'b0;
                bad_exp  = 1'b0;
                target   = (e.s - 1 > last_sampled) ? e.s - 1 : e.s;
                fin      = e.s + 10 * e.d - 1;
                while (!aborted && cyc < target) begin
                    @(negedge clock);
                    if (rst_seen) aborted = 1;
                end
                while (!aborted) begin
                    exp_bit = frame_bit(e, cyc);
                    if (o_tx !== exp_bit && !bad) begin
                        bad     = 1;
                        bad_cyc = cyc;
                        bad_act = o_tx;
                        bad_exp = exp_bit;
                    end
                    last_sampled = cyc;
                    if (cyc >= fin) break;
                    @(negedge clock);
                    if (rst_seen) aborted = 1;
                end
                if (aborted) begin
                    last_sampled = cyc;
                end else begin
                    n_compared++;
                    if (bad) begin
                        n_mismatched++;
                        $display("[TB] FAIL frame 0x%02h div %0d: o_tx=%b at cycle %0d, expected %b",
                                 e.data, e.d, bad_act, bad_cyc, bad_exp);
                    end
                end
                mon_busy = 0;
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by randomized traffic
    initial begin
        bus.address      = 32'h0;
        bus.read_enable  = 1'b0;
        bus.write_enable = 1'b0;
        bus.byte_enable  = 4'h0;
        bus.write_data   = 32'h0;
        m_div            = 16'd868;
        m_ovf            = 1'b0;
        m_irq_en         = 1'b0;
        last_end         = 0;

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        checkOutput("tx_idle_after_reset", {31'h0, o_tx}, 32'h1);
        checkOutput("read_data_no_access", bus.read_data, 32'h0);
`ifdef UART_TX_IRQ_EN
        checkOutput("irq_after_reset", {31'h0, o_irq}, 32'h0);
`endif
        applyStimulus(0, BASE + 32'h4, 4'h0, 32'h0);
        applyStimulus(0, BASE + 32'h8, 4'h0, 32'h0);
        applyStimulus(0, BASE + 32'h0, 4'h0, 32'h0);

        $display("[TB] single frame 0x55 at divisor 4");
        applyStimulus(1, BASE + 32'h8, 4'h3, 32'd4);
        applyStimulus(1, BASE + 32'h0, 4'h1, 32'h55);
        idle(5);
        applyStimulus(0, BASE + 32'h4, 4'h0, 32'h0);
        drain();
        applyStimulus(0, BASE + 32'h4, 4'h0, 32'h0);

        $display("[TB] FIFO fill and overflow at divisor 2");
        applyStimulus(1, BASE + 32'h8, 4'h3, 32'd2);
        for (int i = 0; i < 10; i++) applyStimulus(1, BASE + 32'h0, 4'h1, 32'(8'hA0 + i));
        applyStimulus(0, BASE + 32'h4, 4'h0, 32'h0);
        applyStimulus(1, BASE + 32'h4, 4'hF, 32'h8);
        applyStimulus(0, BASE + 32'h4, 4'h0, 32'h0);
        drain();

        $display("[TB] divisor change mid-frame");
        applyStimulus(1, BASE + 32'h8, 4'h3, 32'd4);
        applyStimulus(1, BASE + 32'h0, 4'h1, 32'hA3);
        idle(10);
        applyStimulus(1, BASE + 32'h8, 4'h3, 32'd6);
        applyStimulus(1, BASE + 32'h0, 4'h1, 32'h3C);
        drain();

        $display("[TB] reset during data bit 3");
        applyStimulus(1, BASE + 32'h8, 4'h3, 32'd4);
        applyStimulus(1, BASE + 32'h0, 4'h1, 32'hC5);
        idle(17);
        do_reset();
        applyStimulus(0, BASE + 32'h4, 4'h0, 32'h0);
        applyStimulus(1, BASE + 32'h8, 4'h2, 32'h0000_AB12);
        applyStimulus(0, BASE + 32'h8, 4'h0, 32'h0);

        $display("[TB] randomized traffic");
        applyStimulus(1, BASE + 32'h8, 4'h3, 32'd2);
        for (int i = 0; i < 200; i++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                applyStimulus(1, BASE + 32'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom);
            end else if (op <= 5) begin
                applyStimulus(0, BASE + 32'($urandom_range(0, 15)), 4'h0, 32'h0);
            end else if (op == 6) begin
                applyStimulus(0, BASE + 32'h10 + 32'($urandom_range(0, 15)), 4'h0, 32'h0);
            end else if (op == 7) begin
                if (frames.size() == 0 || frames[frames.size()-1].s <= cyc + 1)
                    applyStimulus(1, BASE + 32'h8, 4'h3, 32'($urandom_range(0, 3)));
                else
                    idle(1);
            end else if (op == 8) begin
                applyStimulus(1, BASE + 32'h4 + 32'($urandom_range(0, 1) * 8), 4'hF, $urandom);
            end else begin
                idle($urandom_range(1, 30));
            end
        end
        drain();
        applyStimulus(0, BASE + 32'h4, 4'h0, 32'h0);

`ifdef UART_TX_IRQ_EN
        $display("[TB] TX-empty interrupt");
        applyStimulus(1, BASE + 32'hC, 4'h1, 32'h1);
        idle(1);
        @(negedge clock);
        checkOutput("irq_enabled_idle", {31'h0, o_irq}, 32'h1);
        @(posedge clock);
        #1;
        applyStimulus(0, BASE + 32'hC, 4'h0, 32'h0);
        applyStimulus(1, BASE + 32'h0, 4'h1, 32'h5A);
        idle(3);
        @(negedge clock);
        checkOutput("irq_during_frame", {31'h0, o_irq}, 32'h0);
        @(posedge clock);
        #1;
        drain();
        idle(1);
        @(negedge clock);
        checkOutput("irq_after_frame", {31'h0, o_irq}, 32'h1);
        @(posedge clock);
        #1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
